// File: rtl/matmult_sched_if.sv
// Start/Hold request, status and operand/result RAM control bundle for matmult_sched.
// Perf_cycles/Perf_holds exist only when MATMULT_PERF_CNT_EN is defined.
interface matmult_sched_if #(
  parameter int INADDRW  = 4,
  parameter int OUTADDRW = 8
);
  logic                Start;
  logic                Hold;
  logic                Busy;
  logic                Done;
  logic                Start_err;
  logic                Rd_en;
  logic [INADDRW-1:0]  Rd_A_addr;
  logic [INADDRW-1:0]  Rd_B_addr;
  logic                Wr_en;
  logic [OUTADDRW-1:0] Wr_addr;
`ifdef MATMULT_PERF_CNT_EN
  logic [15:0]         Perf_cycles;
  logic [15:0]         Perf_holds;
`endif

  modport master (
    output Start, Hold,
    input  Busy, Done, Start_err, Rd_en, Rd_A_addr, Rd_B_addr, Wr_en, Wr_addr
`ifdef MATMULT_PERF_CNT_EN
    , input Perf_cycles, Perf_holds
`endif
  );

  modport slave (
    input  Start, Hold,
    output Busy, Done, Start_err, Rd_en, Rd_A_addr, Rd_B_addr, Wr_en, Wr_addr
`ifdef MATMULT_PERF_CNT_EN
    , output Perf_cycles, Perf_holds
`endif
  );
endinterface

// File: rtl/matmult_sched.sv
// Issue/drain sequencer for the DIM x DIM matrix-multiply kernel with result-write tracking.
// Optional busy/hold performance counters are enabled by MATMULT_PERF_CNT_EN.
module matmult_sched #(
  parameter int DIM      = 16,
  parameter int INADDRW  = 4,
  parameter int OUTADDRW = 8,
  parameter int LAT      = 6
) (
  input logic            Clk,
  input logic            Rst_n,
  matmult_sched_if.slave sched
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [INADDRW-1:0]  LAST_IDX = INADDRW'(DIM - 1);
  localparam logic [INADDRW-1:0]  IN_ZERO  = {INADDRW{1'b0}};
  localparam logic [OUTADDRW-1:0] OUT_ZERO = {OUTADDRW{1'b0}};
  localparam logic [LAT-2:0]      VLD_ZERO = {(LAT-1){1'b0}};

  state_t              state_q;
  logic [INADDRW-1:0]  row_q;
  logic [INADDRW-1:0]  col_q;
  logic [INADDRW-1:0]  rd_a_q;
  logic [INADDRW-1:0]  rd_b_q;
  logic [OUTADDRW-1:0] wcnt_q;
  logic [OUTADDRW-1:0] wr_addr_q;
  logic [LAT-2:0]      vld_q;
  logic                busy_q;
  logic                done_q;
  logic                start_err_q;
  logic                rd_en_q;
  logic                wr_en_q;

  logic                issue_s;
  logic                run_entry_s;
  logic                last_issue_s;
  logic                drained_s;
  logic                in_busy_s;

  // Decide whether this edge issues a read and whether a new run begins
  always_comb begin
    issue_s     = 1'b0;
    run_entry_s = 1'b0;
    case (state_q)
      IDLE, DONE: begin
        run_entry_s = sched.Start;
        issue_s     = sched.Start & ~sched.Hold;
      end
      RUN: begin
        issue_s = ~sched.Hold;
      end
      DRAIN: begin
        issue_s = 1'b0;
      end
      default: begin
        issue_s = 1'b0;
      end
    endcase
    last_issue_s = issue_s && (row_q == LAST_IDX) && (col_q == LAST_IDX);
    drained_s    = !rd_en_q && (vld_q == VLD_ZERO);
    in_busy_s    = (state_q == RUN) || (state_q == DRAIN);
  end

  // Sequencer state, issue counters, valid pipeline and all registered outputs
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q     <= IDLE;
      row_q       <= IN_ZERO;
      col_q       <= IN_ZERO;
      rd_a_q      <= IN_ZERO;
      rd_b_q      <= IN_ZERO;
      rd_en_q     <= 1'b0;
      vld_q       <= VLD_ZERO;
      wcnt_q      <= OUT_ZERO;
      wr_addr_q   <= OUT_ZERO;
      wr_en_q     <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      start_err_q <= 1'b0;
    end else begin
      start_err_q <= sched.Start & in_busy_s;
      rd_en_q     <= issue_s;
      rd_a_q      <= issue_s ? row_q : IN_ZERO;
      rd_b_q      <= issue_s ? col_q : IN_ZERO;
      if (issue_s) begin
        if (col_q == LAST_IDX) begin
          col_q <= IN_ZERO;
          row_q <= (row_q == LAST_IDX) ? IN_ZERO : row_q + INADDRW'(1);
        end else begin
          col_q <= col_q + INADDRW'(1);
        end
      end else begin
        col_q <= col_q;
      end

      // The valid pipe keeps shifting under Hold so in-flight products still retire in order
      vld_q <= {vld_q[LAT-3:0], rd_en_q};
      if (vld_q[LAT-2]) begin
        wr_en_q   <= 1'b1;
        wr_addr_q <= wcnt_q;
        wcnt_q    <= wcnt_q + OUTADDRW'(1);
      end else begin
        wr_en_q   <= 1'b0;
        wr_addr_q <= OUT_ZERO;
      end
      if (run_entry_s) begin
        wcnt_q <= OUT_ZERO;
      end

      case (state_q)
        IDLE, DONE: begin
          done_q <= 1'b0;
          if (sched.Start) begin
            state_q <= last_issue_s ? DRAIN : RUN;
            busy_q  <= 1'b1;
          end else begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end
        end
        RUN: begin
          state_q <= last_issue_s ? DRAIN : RUN;
          busy_q  <= 1'b1;
          done_q  <= 1'b0;
        end
        DRAIN: begin
          if (drained_s) begin
            state_q <= DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end else begin
            state_q <= DRAIN;
            busy_q  <= 1'b1;
            done_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign sched.Busy      = busy_q;
  assign sched.Done      = done_q;
  assign sched.Start_err = start_err_q;
  assign sched.Rd_en     = rd_en_q;
  assign sched.Rd_A_addr = rd_a_q;
  assign sched.Rd_B_addr = rd_b_q;
  assign sched.Wr_en     = wr_en_q;
  assign sched.Wr_addr   = wr_addr_q;

`ifdef MATMULT_PERF_CNT_EN
  logic [15:0] perf_cycles_q;
  logic [15:0] perf_holds_q;

  // Busy-cycle and held-issue counters, cleared when a run starts and frozen afterwards
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      perf_cycles_q <= 16'd0;
      perf_holds_q  <= 16'd0;
    end else if (run_entry_s) begin
      perf_cycles_q <= 16'd0;
      perf_holds_q  <= 16'd0;
    end else begin
      perf_cycles_q <= busy_q ? perf_cycles_q + 16'd1 : perf_cycles_q;
      perf_holds_q  <= ((state_q == RUN) && sched.Hold) ? perf_holds_q + 16'd1 : perf_holds_q;
    end
  end

  assign sched.Perf_cycles = perf_cycles_q;
  assign sched.Perf_holds  = perf_holds_q;
`endif

endmodule

// File: tb/tb_matmult_sched.sv
// Directed bench for matmult_sched: nominal run, Hold window, Start while busy,
// back-to-back Start, and asynchronous reset mid-run.
module tb_matmult_sched;
  localparam int DIM      = 16;
  localparam int INADDRW  = 4;
  localparam int OUTADDRW = 8;
  localparam int LAT      = 6;
  localparam int NWORDS   = DIM * DIM;
  localparam int T_DONE   = NWORDS + LAT + 1;

  typedef struct {
    logic rd;
    int   idx;
    logic wr;
    int   waddr;
    logic busy;
    logic done;
  } exp_t;

  logic        Clk = 1'b0;
  logic        Rst_n = 1'b1;
  int          checks = 0;
  int          errors = 0;
  int          cyc_tag = 0;
  logic [20:0] outs_s;

  matmult_sched_if #(.INADDRW(INADDRW), .OUTADDRW(OUTADDRW)) sched ();

  matmult_sched #(
    .DIM(DIM), .INADDRW(INADDRW), .OUTADDRW(OUTADDRW), .LAT(LAT)
  ) dut (
    .Clk(Clk),
    .Rst_n(Rst_n),
    .sched(sched)
  );

  always #5 Clk = ~Clk;

  assign outs_s = {sched.Busy, sched.Done, sched.Start_err, sched.Rd_en,
                   sched.Rd_A_addr, sched.Rd_B_addr, sched.Wr_en, sched.Wr_addr};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d: got %0h, expected %0h", tag, cyc_tag, obs, exp);
    end
  endtask

  // Read in run-relative cycle t: suppressed when Hold was high in cycle t-1;
  // idx = number of reads already issued.
  function automatic void exp_rd(input int t, input int h0, input int h1,
                                 output logic en, output int idx);
    int n;
    n   = 0;
    en  = 1'b0;
    idx = 0;
    if (t >= 1) begin
      for (int s = 1; s < t; s++) begin
        if (!((s - 1) >= h0 && (s - 1) <= h1)) n++;
      end
      idx = n;
      en  = !((t - 1) >= h0 && (t - 1) <= h1) && (n < NWORDS);
    end
  endfunction

  function automatic exp_t exp_run(input int t, input int h0, input int h1);
    exp_t e;
    logic en;
    int   idx;
    int   nh;
    nh = (h1 >= h0) ? (h1 - h0 + 1) : 0;
    exp_rd(t, h0, h1, en, idx);
    e.rd  = en;
    e.idx = idx;
    exp_rd(t - LAT, h0, h1, en, idx);
    e.wr    = en;
    e.waddr = en ? idx : 0;
    e.busy  = (t >= 1) && (t <= T_DONE - 1 + nh);
    e.done  = (t == T_DONE + nh);
    return e;
  endfunction

  task automatic reset_dut();
    sched.Start = 1'b0;
    sched.Hold  = 1'b0;
    Rst_n       = 1'b0;
    #1;
    check("rst_outs", 32'(outs_s), 32'd0);
`ifdef MATMULT_PERF_CNT_EN
    check("rst_perf", {sched.Perf_cycles, sched.Perf_holds}, 32'd0);
`endif
    repeat (2) @(negedge Clk);
    Rst_n = 1'b1;
  endtask

  // Cycle c is sampled at its negedge, then inputs for cycle c are applied.
  task automatic run_scn(input string tag, input int ncyc, input int h0, input int h1,
                         input int serr_c, input logic cont);
    exp_t e;
    exp_t e2;
    logic start_prev;
    logic busy_prev;
    int   nh;
    start_prev = 1'b0;
    busy_prev  = 1'b0;
    nh = (h1 >= h0) ? (h1 - h0 + 1) : 0;
    for (int c = 0; c < ncyc; c++) begin
      cyc_tag = c;
      e = exp_run(c, h0, h1);
      if (cont) begin
        e2 = exp_run(c - T_DONE, -1, -2);
        if (e2.rd) begin e.rd = 1'b1; e.idx = e2.idx; end
        if (e2.wr) begin e.wr = 1'b1; e.waddr = e2.waddr; end
        e.busy = e.busy | e2.busy;
        e.done = e.done | e2.done;
      end
      check({tag, ":rd_en"}, 32'(sched.Rd_en), 32'(e.rd));
      if (e.rd) begin
        check({tag, ":rd_addr"}, 32'({sched.Rd_A_addr, sched.Rd_B_addr}),
              32'({4'(e.idx / DIM), 4'(e.idx % DIM)}));
      end
      check({tag, ":wr_en"}, 32'(sched.Wr_en), 32'(e.wr));
      check({tag, ":wr_addr"}, 32'(sched.Wr_addr), 32'(e.waddr));
      check({tag, ":busy"}, 32'(sched.Busy), 32'(e.busy));
      check({tag, ":done"}, 32'(sched.Done), 32'(e.done));
      check({tag, ":start_err"}, 32'(sched.Start_err), 32'(start_prev & busy_prev));
`ifdef MATMULT_PERF_CNT_EN
      if (e.done) begin
        check({tag, ":perf_cycles"}, 32'(sched.Perf_cycles), 32'(T_DONE - 1 + nh));
        check({tag, ":perf_holds"}, 32'(sched.Perf_holds), 32'(nh));
      end
`endif
      sched.Start = (c == 0) || (c == serr_c) || cont;
      sched.Hold  = (c >= h0) && (c <= h1);
      start_prev  = sched.Start;
      busy_prev   = e.busy;
      @(posedge Clk);
      @(negedge Clk);
    end
    sched.Start = 1'b0;
    sched.Hold  = 1'b0;
  endtask

  initial begin
    sched.Start = 1'b0;
    sched.Hold  = 1'b0;
    @(negedge Clk);
    reset_dut();

    run_scn("nominal", T_DONE + 7, -1, -2, -1, 1'b0);
    reset_dut();
    run_scn("hold", T_DONE + 11, 10, 13, -1, 1'b0);
    reset_dut();
    run_scn("serr", T_DONE + 5, -1, -2, 100, 1'b0);
    reset_dut();
    run_scn("cont", T_DONE + 12, -1, -2, -1, 1'b1);
    reset_dut();

    run_scn("prerst", 150, -1, -2, -1, 1'b0);
    cyc_tag = 150;
    check("prerst:busy_before", 32'(sched.Busy), 32'd1);
    reset_dut();
    for (int c = 0; c < 20; c++) begin
      cyc_tag = c;
      check("postrst:wr_en", 32'(sched.Wr_en), 32'd0);
      check("postrst:rd_en", 32'(sched.Rd_en), 32'd0);
      check("postrst:busy", 32'(sched.Busy), 32'd0);
      @(posedge Clk);
      @(negedge Clk);
    end
    run_scn("afterrst", T_DONE + 5, -1, -2, -1, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
